// File: rtl/snoopy_motion.sv
// Snoopy position generator: steps x once per frame tick while running and
// drives a rise/fall jump on y; stops at the last column.
module snoopy_motion #(
    parameter logic [8:0] X_START     = 9'd10,
    parameter logic [8:0] X_END       = 9'd159,
    parameter logic [7:0] Y_GROUND    = 8'd100,
    parameter logic [7:0] JUMP_HEIGHT = 8'd20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       go,
    input  logic       jump,
    output logic [8:0] x_pos,
    output logic [7:0] y_pos,
    output logic       jumping,
    output logic       done,
    output logic       pos_valid
);

    // state | meaning
    // IDLE  | waiting for go; positions held at reset values
    // RUN   | on the ground, x advances on ticks, jump accepted
    // RISE  | y decreases one row per tick up to the apex
    // FALL  | y increases one row per tick back to ground
    // DONE  | last column reached; everything frozen until reset
    typedef enum logic [2:0] {IDLE, RUN, RISE, FALL, DONE} state_t;

    localparam logic [7:0] Y_TOP = Y_GROUND - JUMP_HEIGHT;

    state_t     state;
    state_t     state_next;
    logic [8:0] x_next;
    logic [7:0] y_next;
    logic       x_step;

    always_comb begin
        state_next = state;
        x_next     = x_pos;
        y_next     = y_pos;
        x_step     = 1'b0;

        case (state)
            IDLE: if (go) state_next = RUN;
            RUN:  if (jump) state_next = RISE;
            RISE: begin
                if (frame_tick) begin
                    y_next = y_pos - 8'd1;
                    if (y_next == Y_TOP) state_next = FALL;
                end
            end
            FALL: begin
                if (frame_tick) begin
                    y_next = y_pos + 8'd1;
                    if (y_next == Y_GROUND) state_next = RUN;
                end
            end
            DONE:    state_next = DONE;
            default: state_next = IDLE;
        endcase

        x_step = frame_tick && go &&
                 ((state == RUN) || (state == RISE) || (state == FALL));

        // Reaching the last column overrides any jump and lands Snoopy at once.
        if (x_step) begin
            x_next = x_pos + 9'd1;
            if (x_next == X_END) begin
                state_next = DONE;
                y_next     = Y_GROUND;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            x_pos     <= X_START;
            y_pos     <= Y_GROUND;
            pos_valid <= 1'b0;
        end else begin
            state     <= state_next;
            x_pos     <= x_next;
            y_pos     <= y_next;
            pos_valid <= (x_next != x_pos) || (y_next != y_pos);
        end
    end

    assign jumping = (state == RISE) || (state == FALL);
    assign done    = (state == DONE);

endmodule

// File: tb/tb_snoopy_motion.sv
// Self-checking bench for snoopy_motion: directed scenarios plus random
// stimulus compared against a tick-count based reference model.
module tb_snoopy_motion;

    localparam int X_START  = 10;
    localparam int X_END    = 159;
    localparam int Y_GROUND = 100;
    localparam int H        = 20;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic       go = 1'b0;
    logic       jump = 1'b0;
    logic [8:0] x_pos;
    logic [7:0] y_pos;
    logic       jumping;
    logic       done;
    logic       pos_valid;

    int errors = 0;
    int checks = 0;

    // Reference model: run phase flags and ticks spent airborne.
    bit m_started, m_finished, m_in_air, m_pv;
    int m_air, m_x, m_y;

    snoopy_motion dut (
        .clock     (clock),
        .reset     (reset),
        .frame_tick(frame_tick),
        .go        (go),
        .jump      (jump),
        .x_pos     (x_pos),
        .y_pos     (y_pos),
        .jumping   (jumping),
        .done      (done),
        .pos_valid (pos_valid)
    );

    always #5 clock = ~clock;

    function automatic void model_update(input bit r, input bit g, input bit j, input bit t);
        int ox, oy;
        ox = m_x;
        oy = m_y;
        if (r) begin
            m_started = 0; m_finished = 0; m_in_air = 0; m_air = 0;
            m_x = X_START; m_y = Y_GROUND; m_pv = 0;
            return;
        end
        if (!m_started) begin
            if (g) m_started = 1;
        end else if (!m_finished) begin
            if (m_in_air) begin
                if (t) begin
                    m_air++;
                    if (m_air == 2 * H) begin
                        m_in_air = 0;
                        m_air = 0;
                    end
                end
            end else if (j) begin
                m_in_air = 1;
                m_air = 0;
            end
            if (t && g) begin
                m_x++;
                if (m_x == X_END) begin
                    m_finished = 1;
                    m_in_air = 0;
                    m_air = 0;
                end
            end
        end
        m_y  = Y_GROUND - ((m_air <= H) ? m_air : 2 * H - m_air);
        m_pv = (m_x != ox) || (m_y != oy);
    endfunction

    function automatic logic [19:0] dut_vec();
        return {x_pos, y_pos, jumping, done, pos_valid};
    endfunction

    function automatic logic [19:0] exp_vec();
        return {9'(m_x), 8'(m_y), logic'(m_in_air), logic'(m_finished), logic'(m_pv)};
    endfunction

    task automatic step(input bit r, input bit g, input bit j, input bit t);
        reset = r; go = g; jump = j; frame_tick = t;
        @(posedge clock);
        model_update(r, g, j, t);
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0);
        step(1, 1, 1, 1);
        checks++;
        if ({x_pos, y_pos, jumping, done, pos_valid} !== {9'd10, 8'd100, 3'b000}) begin
            errors++;
            $display("FAIL reset_values: got x=%0d y=%0d j=%b d=%b v=%b, want x=10 y=100 j=0 d=0 v=0",
                     x_pos, y_pos, jumping, done, pos_valid);
        end
        step(0, 0, 0, 1);
        checks++;
        if (dut_vec() !== exp_vec() || x_pos !== 9'd10 || pos_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_tick: got %h, want %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_walk();
        int pulses = 0;
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        checks++;
        if (x_pos !== 9'd10 || pos_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL start_no_move: got x=%0d v=%b d=%b, want x=10 v=0 d=0", x_pos, pos_valid, done);
        end
        for (int i = 1; i <= 149; i++) begin
            step(0, 1, 0, 1);
            if (pos_valid === 1'b1) pulses++;
            checks++;
            if (x_pos !== 9'(X_START + i) || y_pos !== 8'd100 || dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL walk_step%0d: got x=%0d y=%0d vec=%h, want x=%0d y=100 vec=%h",
                         i, x_pos, y_pos, dut_vec(), X_START + i, exp_vec());
            end
        end
        checks++;
        if (pulses != 149 || done !== 1'b1) begin
            errors++;
            $display("FAIL walk_end: got pulses=%0d done=%b, want pulses=149 done=1", pulses, done);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 1);
            checks++;
            if (x_pos !== 9'd159 || pos_valid !== 1'b0 || done !== 1'b1) begin
                errors++;
                $display("FAIL done_hold: got x=%0d v=%b d=%b, want x=159 v=0 d=1", x_pos, pos_valid, done);
            end
        end
    endtask

    task automatic test_jump();
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        for (int i = 0; i < 30; i++) step(0, 1, 0, 1);
        step(0, 1, 1, 0);
        checks++;
        if (x_pos !== 9'd40 || y_pos !== 8'd100 || jumping !== 1'b1 || pos_valid !== 1'b0) begin
            errors++;
            $display("FAIL jump_start: got x=%0d y=%0d j=%b v=%b, want x=40 y=100 j=1 v=0",
                     x_pos, y_pos, jumping, pos_valid);
        end
        for (int i = 1; i <= 40; i++) begin
            step(0, 1, 0, 1);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL jump_tick%0d: got %h, want %h", i, dut_vec(), exp_vec());
            end
            if (i == 20) begin
                checks++;
                if (y_pos !== 8'd80 || jumping !== 1'b1) begin
                    errors++;
                    $display("FAIL jump_apex: got y=%0d j=%b, want y=80 j=1", y_pos, jumping);
                end
            end
        end
        checks++;
        if (x_pos !== 9'd80 || y_pos !== 8'd100 || jumping !== 1'b0) begin
            errors++;
            $display("FAIL jump_land: got x=%0d y=%0d j=%b, want x=80 y=100 j=0", x_pos, y_pos, jumping);
        end
    endtask

    task automatic test_go_pause();
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 1);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 1);
            checks++;
            if (x_pos !== 9'd15 || pos_valid !== 1'b1 || dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL pause_tick%0d: got x=%0d v=%b vec=%h, want x=15 v=1 vec=%h",
                         i, x_pos, pos_valid, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (y_pos !== 8'd85) begin
            errors++;
            $display("FAIL pause_y: got y=%0d, want y=85", y_pos);
        end
    endtask

    task automatic test_end_midair();
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        for (int i = 0; i < 140; i++) step(0, 1, 0, 1);
        step(0, 1, 1, 0);
        for (int i = 0; i < 9; i++) step(0, 1, 0, 1);
        checks++;
        if (x_pos !== 9'd159 || y_pos !== 8'd100 || done !== 1'b1 || jumping !== 1'b0 || pos_valid !== 1'b1) begin
            errors++;
            $display("FAIL end_midair: got x=%0d y=%0d d=%b j=%b v=%b, want x=159 y=100 d=1 j=0 v=1",
                     x_pos, y_pos, done, jumping, pos_valid);
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 1, 1);
            checks++;
            if (dut_vec() !== exp_vec() || pos_valid !== 1'b0) begin
                errors++;
                $display("FAIL end_hold%0d: got %h, want %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_midjump();
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        for (int i = 0; i < 41; i++) step(0, 1, 0, 1);
        step(0, 1, 1, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 1);
        checks++;
        if (x_pos !== 9'd61 || y_pos !== 8'd90 || jumping !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: got x=%0d y=%0d j=%b, want x=61 y=90 j=1", x_pos, y_pos, jumping);
        end
        step(1, 1, 1, 1);
        checks++;
        if ({x_pos, y_pos, jumping, done, pos_valid} !== {9'd10, 8'd100, 3'b000}) begin
            errors++;
            $display("FAIL reset_midjump: got x=%0d y=%0d j=%b d=%b v=%b, want x=10 y=100 j=0 d=0 v=0",
                     x_pos, y_pos, jumping, done, pos_valid);
        end
        step(0, 0, 0, 1);
        checks++;
        if (x_pos !== 9'd10 || pos_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_is_idle: got x=%0d v=%b, want x=10 v=0", x_pos, pos_valid);
        end
    endtask

    task automatic test_ignored_jump();
        step(1, 0, 0, 0);
        step(0, 0, 1, 1);
        checks++;
        if (jumping !== 1'b0 || dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL idle_jump: got %h, want %h", dut_vec(), exp_vec());
        end
        step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        for (int i = 1; i <= 40; i++) begin
            step(0, 1, (i < 40), 1);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL held_jump%0d: got %h, want %h", i, dut_vec(), exp_vec());
            end
        end
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 1);
            checks++;
            if (jumping !== 1'b0 || y_pos !== 8'd100) begin
                errors++;
                $display("FAIL no_requeue%0d: got j=%b y=%0d, want j=0 y=100", i, jumping, y_pos);
            end
        end
    endtask

    task automatic test_random();
        bit r, g, j, t;
        step(1, 0, 0, 0);
        for (int i = 0; i < 4000; i++) begin
            r = ($urandom_range(999) < 2);
            g = ($urandom_range(99) < 75);
            j = ($urandom_range(99) < 6);
            t = ($urandom_range(99) < 35);
            step(r, g, j, t);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random%0d: got x=%0d y=%0d jdv=%b%b%b, want x=%0d y=%0d jdv=%b%b%b",
                         i, x_pos, y_pos, jumping, done, pos_valid,
                         m_x, m_y, m_in_air, m_finished, m_pv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_walk();
        test_jump();
        test_go_pause();
        test_end_midair();
        test_reset_midjump();
        test_ignored_jump();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
